// File: rtl/ls161_pkg.sv
// rtl/ls161_pkg.sv - shared types and constants for the My74LS161 sequencer
//
// Purpose: state encoding for the sequencer FSM and the counter terminal value.
// Ports: none (package).
package ls161_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRELOAD = 3'd1,
      RUN     = 3'd2,
      DONE    = 3'd3,
      ABORT   = 3'd4
   } state_t;

   localparam logic [3:0] LS161_MAX = 4'd15;

endpackage

// File: rtl/ls161_seq_ctrl.sv
// rtl/ls161_seq_ctrl.sv - programmable divider/timer sequencer for one My74LS161
//
// Purpose: drives the CR/Ld/CTT/CTP/D pins of a 4-bit counter so that it counts a
// mod-(16-preset) period, reloading on terminal count, and counts a programmable
// number of terminal events per run (one-shot or auto-restart).
// Ports:
//   CP, CR                 clock (rising edge) and asynchronous active-high reset
//   start, abort           one-cycle host requests; abort has highest priority
//   pause                  level; freezes counting while high in RUN
//   preset, cycles         run operands, latched on an accepted start
//   reload_mode            0 one-shot, 1 auto-restart
//   ctr_q, ctr_co          counter Q and carry-out
//   ctr_cr_n, ctr_ld_n     counter clear / synchronous load, active-low
//   ctr_ctt, ctr_ctp, ctr_d counter enables and load data
//   busy, tick, done, err  host status; tick/done/err are one-cycle pulses
//   remaining              terminal counts left in the current run
module ls161_seq_ctrl
   import ls161_pkg::*;
#(
   parameter int CYC_W = 8
) (
   input  logic             CP,
   input  logic             CR,
   input  logic             start,
   input  logic [3:0]       preset,
   input  logic [CYC_W-1:0] cycles,
   input  logic             reload_mode,
   input  logic             pause,
   input  logic             abort,
   input  logic [3:0]       ctr_q,
   input  logic             ctr_co,
   output logic             ctr_cr_n,
   output logic             ctr_ld_n,
   output logic             ctr_ctt,
   output logic             ctr_ctp,
   output logic [3:0]       ctr_d,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic             err,
   output logic [CYC_W-1:0] remaining
);

   localparam logic [CYC_W-1:0] ONE = CYC_W'(1);

   state_t           state, state_nx;
   logic [3:0]       preset_r;
   logic [CYC_W-1:0] cycles_r;
   logic             mode_r;
   logic             err_r;
   logic             done_r;
   logic             qual;
   logic             clr;
   logic             done_st;

   // A terminal count only counts while running and not paused; while paused at
   // Q==15 the load stays off and CTP is low, so the counter simply holds 15.
   assign qual = (state == RUN) & ctr_co & (ctr_q == LS161_MAX) & ~pause;

   always_comb begin
      state_nx = state;
      ctr_ctt  = 1'b0;
      ctr_ctp  = 1'b0;
      ctr_ld_n = 1'b1;
      clr      = 1'b0;
      busy     = 1'b0;
      tick     = 1'b0;
      done_st  = 1'b0;
      case (state)
         IDLE: begin
            if (start && (cycles != '0))
               state_nx = PRELOAD;
         end
         PRELOAD: begin
            busy     = 1'b1;
            ctr_ld_n = 1'b0;
            state_nx = abort ? ABORT : RUN;
         end
         RUN: begin
            busy     = 1'b1;
            ctr_ctt  = 1'b1;
            ctr_ctp  = ~pause;
            tick     = qual;
            // Reload the preset instead of letting the counter wrap 15->0.
            ctr_ld_n = ~qual;
            if (abort)
               state_nx = ABORT;
            else if (qual && (remaining == ONE) && !mode_r)
               state_nx = DONE;
         end
         DONE: begin
            done_st  = 1'b1;
            state_nx = abort ? ABORT : IDLE;
         end
         ABORT: begin
            clr      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Clear follows CR combinationally so the counter is held clear during reset.
   assign ctr_cr_n = ~(CR | clr);
   assign ctr_d    = preset_r;
   assign done     = done_st | done_r;
   assign err      = err_r;

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state     <= IDLE;
         preset_r  <= 4'd0;
         cycles_r  <= '0;
         mode_r    <= 1'b0;
         remaining <= '0;
         err_r     <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state  <= state_nx;
         err_r  <= 1'b0;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cycles != '0) begin
                     preset_r  <= preset;
                     cycles_r  <= cycles;
                     mode_r    <= reload_mode;
                     remaining <= cycles;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (qual && !abort) begin
                  if ((remaining == ONE) && mode_r) begin
                     remaining <= cycles_r;
                     done_r    <= 1'b1;
                  end else begin
                     remaining <= remaining - ONE;
                  end
               end
            end
            ABORT: remaining <= '0;
            default: ;
         endcase
      end
   end

endmodule
